dht11_single_wire_reader: RTL and testbench

- Self-timed reader for a DHT11 humidity/temperature sensor on a bidirectional open-drain data line.
- An internal divider makes a 1 µs tick from the system clock. A protocol FSM runs one complete sensor transaction per enable and returns five data bytes plus done/error flags.
- Sits under the sensor controller, which raises enable, waits for done, samples the bytes/error, then drops enable.

---
 rtl/dht11_single_wire_reader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dht11_single_wire_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_single_wire_reader.sv
// DHT11 single-wire reader: 1 us tick generator plus a protocol FSM that runs one
// sensor transaction per enable request and returns the five frame bytes.
module dht11_single_wire_reader #(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int TICKS_PER_US     = CLK_FREQ_HZ / 1_000_000,
    parameter int START_LOW_US     = 18_000,
    parameter int BIT_THRESHOLD_US = 40,
    parameter int TIMEOUT_US       = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    inout  wire        dado,
    output logic       us_tick,
    output logic       erro,
    output logic       terminou,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic [7:0] checksum
);

    localparam int TICK_W  = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int CNT_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int US_W    = $clog2(CNT_MAX + 2);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_US - 1);
    localparam logic [US_W-1:0]   START_CNT   = US_W'(START_LOW_US);
    localparam logic [US_W-1:0]   TIMEOUT_CNT = US_W'(TIMEOUT_US);
    localparam logic [US_W-1:0]   THRESH_CNT  = US_W'(BIT_THRESHOLD_US);
    localparam logic [US_W-1:0]   US_SAT      = {US_W{1'b1}};

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_RELEASE   = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    // Modulo-256 sum of the four payload bytes (frame[39:8]).
    function automatic logic [7:0] frame_sum(input logic [39:0] frame);
        return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    endfunction

    state_t              state_r, state_nxt_s;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic                us_tick_r;
    logic [2:0]          sync_r;
    logic [US_W-1:0]     us_cnt_r;
    logic [5:0]          bit_idx_r;
    logic [39:0]         shift_r;
    logic                drive_low_r, erro_r, terminou_r;
    logic [7:0]          hum_int_r, hum_dec_r, temp_int_r, temp_dec_r, checksum_r;

    logic line_s, fall_s, timed_out_s, abort_s;
    logic shift_en_s, bit_val_s, idx_inc_s, idx_clr_s, frame_clr_s, latch_s, timeout_s;

    assign dado        = drive_low_r ? 1'b0 : 1'bz;
    // sync_r[1] is the synchronized level; sync_r[2] its previous value for edge detection.
    assign line_s      = sync_r[1];
    assign fall_s      = sync_r[2] & ~sync_r[1];
    assign timed_out_s = (us_cnt_r >= TIMEOUT_CNT);
    assign abort_s     = ~enable && (state_r != ST_IDLE) && (state_r != ST_DONE);

    // Free-running 1 us tick generator.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            us_tick_r  <= 1'b0;
        end else begin
            us_tick_r  <= (tick_cnt_r == TICK_LAST);
            tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
        end
    end

    // Two-flop synchronizer for the sensor line plus one history stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[1:0], dado};
        end
    end

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        shift_en_s  = 1'b0;
        bit_val_s   = 1'b0;
        idx_inc_s   = 1'b0;
        idx_clr_s   = 1'b0;
        frame_clr_s = 1'b0;
        latch_s     = 1'b0;
        timeout_s   = 1'b0;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt_s = ST_START_LOW;
                        frame_clr_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START_LOW: begin
                    if (us_cnt_r >= START_CNT) begin
                        state_nxt_s = ST_RELEASE;
                    end else begin
                        state_nxt_s = ST_START_LOW;
                    end
                end
                // Wait for a true falling edge so our own released drive is not mistaken for the sensor.
                ST_RELEASE: begin
                    if (fall_s) begin
                        state_nxt_s = ST_RESP_LOW;
                    end else if (timed_out_s) begin
                        state_nxt_s = ST_DONE;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RELEASE;
                    end
                end
                ST_RESP_LOW: begin
                    if (line_s) begin
                        state_nxt_s = ST_RESP_HIGH;
                    end else if (timed_out_s) begin
                        state_nxt_s = ST_DONE;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RESP_LOW;
                    end
                end
                ST_RESP_HIGH: begin
                    if (!line_s) begin
                        state_nxt_s = ST_BIT_LOW;
                        idx_clr_s   = 1'b1;
                    end else if (timed_out_s) begin
                        state_nxt_s = ST_DONE;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RESP_HIGH;
                    end
                end
                ST_BIT_LOW: begin
                    if (line_s) begin
                        state_nxt_s = ST_BIT_HIGH;
                    end else if (timed_out_s) begin
                        state_nxt_s = ST_DONE;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_BIT_LOW;
                    end
                end
                ST_BIT_HIGH: begin
                    if (!line_s) begin
                        shift_en_s = 1'b1;
                        bit_val_s  = (us_cnt_r > THRESH_CNT);
                        if (bit_idx_r == 6'd39) begin
                            state_nxt_s = ST_CHECK;
                        end else begin
                            state_nxt_s = ST_BIT_LOW;
                            idx_inc_s   = 1'b1;
                        end
                    end else if (timed_out_s) begin
                        state_nxt_s = ST_DONE;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_BIT_HIGH;
                    end
                end
                ST_CHECK: begin
                    latch_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end
                ST_DONE: begin
                    if (!enable) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Per-state microsecond counter, bit index and frame shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            us_cnt_r  <= {US_W{1'b0}};
            bit_idx_r <= 6'd0;
            shift_r   <= 40'd0;
        end else begin
            if (state_nxt_s != state_r) begin
                us_cnt_r <= {US_W{1'b0}};
            end else if (us_tick_r && (us_cnt_r != US_SAT)) begin
                us_cnt_r <= us_cnt_r + US_W'(1);
            end
            if (idx_clr_s) begin
                bit_idx_r <= 6'd0;
            end else if (idx_inc_s) begin
                bit_idx_r <= bit_idx_r + 6'd1;
            end
            if (frame_clr_s) begin
                shift_r <= 40'd0;
            end else if (shift_en_s) begin
                shift_r <= {shift_r[38:0], bit_val_s};
            end
        end
    end

    // Registered outputs: line drive, status flags and latched bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            drive_low_r <= 1'b0;
            terminou_r  <= 1'b0;
            erro_r      <= 1'b0;
            hum_int_r   <= 8'd0;
            hum_dec_r   <= 8'd0;
            temp_int_r  <= 8'd0;
            temp_dec_r  <= 8'd0;
            checksum_r  <= 8'd0;
        end else begin
            drive_low_r <= (state_nxt_s == ST_START_LOW);
            terminou_r  <= (state_nxt_s == ST_DONE);
            if (latch_s) begin
                erro_r <= (frame_sum(shift_r) != shift_r[7:0]);
            end else if (timeout_s) begin
                erro_r <= 1'b1;
            end else if (state_nxt_s == ST_IDLE) begin
                erro_r <= 1'b0;
            end
            if (latch_s) begin
                hum_int_r  <= shift_r[39:32];
                hum_dec_r  <= shift_r[31:24];
                temp_int_r <= shift_r[23:16];
                temp_dec_r <= shift_r[15:8];
                checksum_r <= shift_r[7:0];
            end
        end
    end

    assign us_tick  = us_tick_r;
    assign erro     = erro_r;
    assign terminou = terminou_r;
    assign hum_int  = hum_int_r;
    assign hum_dec  = hum_dec_r;
    assign temp_int = temp_int_r;
    assign temp_dec = temp_dec_r;
    assign checksum = checksum_r;

endmodule

// File: tb/tb_dht11_single_wire_reader.sv
// Scoreboard bench for the DHT11 reader with a behavioural open-drain sensor model.
module tb_dht11_single_wire_reader;

    localparam int CLK_HZ   = 2_000_000;
    localparam int TPU      = CLK_HZ / 1_000_000;
    localparam int START_US = 200;
    localparam int THR_US   = 40;
    localparam int TMO_US   = 100;

    localparam logic [39:0] FRAME_A = 40'h37_00_19_00_50;
    localparam logic [39:0] FRAME_B = 40'h37_00_19_00_51;
    localparam logic [39:0] FRAME_C = 40'h2A_01_14_02_41;
    localparam logic [39:0] FRAME_D = 40'h41_05_1C_03_65;

    typedef struct packed {
        logic        err;
        logic [39:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       sens_low;
    wire        dado;
    logic       us_tick, erro, terminou;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec, checksum;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    assign dado = sens_low ? 1'b0 : 1'bz;
    pullup (dado);

    always #5 clk = ~clk;

    dht11_single_wire_reader #(
        .CLK_FREQ_HZ     (CLK_HZ),
        .START_LOW_US    (START_US),
        .BIT_THRESHOLD_US(THR_US),
        .TIMEOUT_US      (TMO_US)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .dado    (dado),
        .us_tick (us_tick),
        .erro    (erro),
        .terminou(terminou),
        .hum_int (hum_int),
        .hum_dec (hum_dec),
        .temp_int(temp_int),
        .temp_dec(temp_dec),
        .checksum(checksum)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_us(input int us);
        repeat (us * TPU) @(negedge clk);
    endtask

    // Scoreboard monitor: compares on every rising edge of terminou.
    initial begin : monitor
        logic term_q;
        exp_t e;
        term_q = 1'b0;
        forever begin
            @(negedge clk);
            if (terminou === 1'b1 && term_q === 1'b0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: terminou rose with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_erro",     erro,     e.err);
                    check("sb_hum_int",  hum_int,  e.frame[39:32]);
                    check("sb_hum_dec",  hum_dec,  e.frame[31:24]);
                    check("sb_temp_int", temp_int, e.frame[23:16]);
                    check("sb_temp_dec", temp_dec, e.frame[15:8]);
                    check("sb_checksum", checksum, e.frame[7:0]);
                end
            end
            term_q = terminou;
        end
    end

    task automatic expect_result(input logic err, input logic [39:0] frame);
        exp_t e;
        e.err   = err;
        e.frame = frame;
        sb_q.push_back(e);
    endtask

    // Waits for the host start pulse and checks its width; ok=1 once the line is released.
    task automatic measure_start(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (dado !== 1'b0 && n < 20 * TPU) begin
            @(negedge clk);
            n++;
        end
        if (dado !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL start_seen: no start pulse within %0d clk", n);
        end else begin
            n = 0;
            while (dado === 1'b0 && n < (START_US + 20) * TPU) begin
                @(negedge clk);
                n++;
            end
            check_range("start_low_clk", n, (START_US - 1) * TPU, (START_US + 1) * TPU);
            ok = (dado === 1'b1);
        end
    endtask

    // Sensor model: response, 40 bits MSB first, optional stuck-low or early stop.
    task automatic send_frame(input logic [39:0] f, input int stuck_bit, input int stop_bit);
        bit ended;
        ended = 1'b0;
        wait_us(30);
        sens_low = 1'b1;
        wait_us(80);
        sens_low = 1'b0;
        wait_us(80);
        for (int i = 0; i < 40; i++) begin
            if (!ended) begin
                if (i == stop_bit) begin
                    ended = 1'b1;
                end else if (i == stuck_bit) begin
                    sens_low = 1'b1;
                    wait_us(150);
                    sens_low = 1'b0;
                    ended = 1'b1;
                end else begin
                    sens_low = 1'b1;
                    wait_us(50);
                    sens_low = 1'b0;
                    wait_us(f[39 - i] ? 70 : 27);
                end
            end
        end
        if (!ended) begin
            sens_low = 1'b1;
            wait_us(50);
            sens_low = 1'b0;
        end
    endtask

    task automatic wait_terminou(input string name, input int budget_us);
        int n;
        n = 0;
        while (terminou !== 1'b1 && n < budget_us * TPU) begin
            @(negedge clk);
            n++;
        end
        if (terminou !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: terminou not seen within %0d us", name, budget_us);
        end
    endtask

    task automatic ack();
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ack_terminou", terminou, 1'b0);
        check("ack_erro", erro, 1'b0);
    endtask

    task automatic full_read(input logic [39:0] f, input logic exp_err, input logic [39:0] exp_frame);
        bit ok;
        expect_result(exp_err, exp_frame);
        enable = 1'b1;
        measure_start(ok);
        if (ok) begin
            send_frame(f, 99, 99);
        end
        wait_terminou("read_done", 300);
    endtask

    // Whole-run watchdog.
    initial begin
        #(800_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        int n;
        bit saw_low;
        reset    = 1'b1;
        enable   = 1'b0;
        sens_low = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_us_tick", us_tick, 1'b0);
        check("rst_terminou", terminou, 1'b0);
        check("rst_erro", erro, 1'b0);
        check("rst_bytes", {hum_int, hum_dec, temp_int, temp_dec, checksum}, 40'd0);
        check("rst_dado_hiz", dado, 1'b1);
        reset = 1'b0;

        // Tick spacing.
        n = 0;
        while (us_tick !== 1'b1 && n < 10 * TPU) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (us_tick !== 1'b1 && n < 10 * TPU);
            check_range("tick_period", n, TPU, TPU);
        end

        // Good frame, then bad checksum.
        full_read(FRAME_A, 1'b0, FRAME_A);
        ack();
        full_read(FRAME_B, 1'b1, FRAME_B);
        ack();

        // No sensor response: timeout after release, bytes unchanged.
        expect_result(1'b1, FRAME_B);
        enable = 1'b1;
        measure_start(ok);
        n = 0;
        while (terminou !== 1'b1 && n < 200 * TPU) begin
            @(negedge clk);
            n++;
        end
        check_range("noresp_timeout_clk", n, (TMO_US - 1) * TPU, (TMO_US + 1) * TPU);
        ack();

        // Line stuck low in bit 12.
        expect_result(1'b1, FRAME_B);
        enable = 1'b1;
        measure_start(ok);
        if (ok) begin
            send_frame(FRAME_C, 12, 99);
        end
        wait_terminou("stuck_done", 50);
        ack();

        // Abort during the start pulse.
        enable = 1'b1;
        n = 0;
        while (dado !== 1'b0 && n < 20 * TPU) begin
            @(negedge clk);
            n++;
        end
        wait_us(10);
        enable = 1'b0;
        @(negedge clk);
        check("abort_start_hiz", dado, 1'b1);
        check("abort_start_terminou", terminou, 1'b0);

        // Abort mid-frame while waiting on bit 8.
        enable = 1'b1;
        measure_start(ok);
        if (ok) begin
            send_frame(FRAME_C, 99, 8);
        end
        wait_us(5);
        enable = 1'b0;
        @(negedge clk);
        check("abort_mid_hiz", dado, 1'b1);
        check("abort_mid_terminou", terminou, 1'b0);
        check("abort_mid_erro", erro, 1'b0);
        check("abort_mid_bytes", {hum_int, hum_dec, temp_int, temp_dec, checksum}, FRAME_B);
        wait_us(150);
        check("abort_mid_no_done", terminou, 1'b0);

        // Hold enable after done: no retrigger; then drop/raise starts a new read.
        full_read(FRAME_A, 1'b0, FRAME_A);
        saw_low = 1'b0;
        for (int k = 0; k < 1000 * TPU; k++) begin
            @(negedge clk);
            if (dado === 1'b0) saw_low = 1'b1;
        end
        check("hold_no_start", saw_low, 1'b0);
        check("hold_terminou", terminou, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        full_read(FRAME_D, 1'b0, FRAME_D);
        ack();

        repeat (4) @(negedge clk);
        check("sb_empty", sb_q.size(), 40'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
